// File: rtl/l1d_miss_ctrl_if.sv
// Signal bundle between the L1D miss controller and its lookup pipeline, arrays, PLRU and memory.
// The master modport is the controller's view; the slave modport is the surrounding system's view.
interface l1d_miss_ctrl_if #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned LINE_W   = 128
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  logic              miss_valid;
  logic              miss_ready;
  logic [ADDR_W-1:0] miss_addr;
  logic [WAY_W-1:0]  plru_victim;
  logic              plru_update;
  logic [WAY_W-1:0]  plru_way;
  logic              arr_rd_en;
  logic [INDEX_W-1:0] arr_index;
  logic [WAY_W-1:0]  arr_way;
  logic              arr_rd_valid;
  logic              arr_rd_dirty;
  logic [TAG_W-1:0]  arr_rd_tag;
  logic [LINE_W-1:0] arr_rd_data;
  logic              arr_wr_en;
  logic [TAG_W-1:0]  arr_wr_tag;
  logic [LINE_W-1:0] arr_wr_data;
  logic              arr_wr_dirty;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;
  logic              busy;

  modport master (
    input  miss_valid, miss_addr, plru_victim,
    input  arr_rd_valid, arr_rd_dirty, arr_rd_tag, arr_rd_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output miss_ready, plru_update, plru_way,
    output arr_rd_en, arr_index, arr_way, arr_wr_en, arr_wr_tag, arr_wr_data, arr_wr_dirty,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, busy
  );

  modport slave (
    output miss_valid, miss_addr, plru_victim,
    output arr_rd_valid, arr_rd_dirty, arr_rd_tag, arr_rd_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  miss_ready, plru_update, plru_way,
    input  arr_rd_en, arr_index, arr_way, arr_wr_en, arr_wr_tag, arr_wr_data, arr_wr_dirty,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, busy
  );
endinterface

// File: rtl/l1d_miss_ctrl.sv
// Single-outstanding L1D miss handler: reads victim metadata, writes back a dirty victim,
// refills the line from memory, writes it into the arrays and marks the way MRU in the PLRU.
module l1d_miss_ctrl #(
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INDEX_W  = 6,
  parameter int unsigned OFFSET_W = 4,
  parameter int unsigned LINE_W   = 128
) (
  input logic            clk,
  input logic            rst_n,
  l1d_miss_ctrl_if.master bus
);
  localparam int unsigned WAY_W = $clog2(NUM_WAYS);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFFSET_W;

  typedef enum logic [2:0] {
    StIdle, StRdMeta, StEval, StWbReq, StRfReq, StRfWait, StFill
  } state_e;

  state_e              state_q, state_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [INDEX_W-1:0]  index_q, index_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [LINE_W-1:0]   wb_data_q, wb_data_d;
  logic [LINE_W-1:0]   line_q, line_d;

  // Byte offset within the line is irrelevant: all memory traffic is line-aligned.
  logic unused_offset;
  assign unused_offset = ^bus.miss_addr[OFFSET_W-1:0];

  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    index_d   = index_q;
    victim_d  = victim_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    line_d    = line_q;
    case (state_q)
      StIdle: begin
        if (bus.miss_valid) begin
          tag_d    = bus.miss_addr[ADDR_W-1 -: TAG_W];
          index_d  = bus.miss_addr[OFFSET_W +: INDEX_W];
          victim_d = bus.plru_victim;
          state_d  = StRdMeta;
        end
      end
      StRdMeta: state_d = StEval;
      StEval: begin
        if (bus.arr_rd_valid && bus.arr_rd_dirty) begin
          wb_addr_d = {bus.arr_rd_tag, index_q, {OFFSET_W{1'b0}}};
          wb_data_d = bus.arr_rd_data;
          state_d   = StWbReq;
        end else begin
          state_d = StRfReq;
        end
      end
      StWbReq: if (bus.mem_req_ready) state_d = StRfReq;
      StRfReq: if (bus.mem_req_ready) state_d = StRfWait;
      StRfWait: begin
        if (bus.mem_resp_valid) begin
          line_d  = bus.mem_resp_data;
          state_d = StFill;
        end
      end
      StFill:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tag_q     <= '0;
      index_q   <= '0;
      victim_q  <= '0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      line_q    <= '0;
    end else begin
      state_q   <= state_d;
      tag_q     <= tag_d;
      index_q   <= index_d;
      victim_q  <= victim_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      line_q    <= line_d;
    end
  end

  // miss_ready is gated by rst_n so a miss presented during reset is never handshaken.
  always_comb begin
    bus.miss_ready    = (state_q == StIdle) && rst_n;
    bus.busy          = (state_q != StIdle);
    bus.arr_rd_en     = (state_q == StRdMeta);
    bus.arr_index     = index_q;
    bus.arr_way       = victim_q;
    bus.arr_wr_en     = (state_q == StFill);
    bus.arr_wr_tag    = tag_q;
    bus.arr_wr_data   = line_q;
    bus.arr_wr_dirty  = 1'b0;
    bus.plru_update   = (state_q == StFill);
    bus.plru_way      = victim_q;
    bus.mem_req_valid = (state_q == StWbReq) || (state_q == StRfReq);
    bus.mem_req_we    = (state_q == StWbReq);
    bus.mem_req_addr  = (state_q == StWbReq) ? wb_addr_q : {tag_q, index_q, {OFFSET_W{1'b0}}};
    bus.mem_req_wdata = wb_data_q;
  end
endmodule
